// File: rtl/silife_grid_sync_edge_lanes.sv
// silife_grid_sync_edge_lanes
//   Exchanges one grid edge (WIDTH cells + corner) with the neighbouring chip
//   over LANES serial wires per direction, with optional per-lane even parity.
//   TX snapshots the outgoing edge on start and streams BEATS beats; RX
//   collects beats into a shadow register and commits atomically on a clean,
//   complete frame.
//
// Ports:
//   i_sync_clk     clock, all logic on posedge
//   reset          synchronous, active-high
//   i_start        transmit request (pulse or level), ignored while busy
//   i_cells        outgoing edge cells, sampled on accepted start
//   i_corner       outgoing corner cell, sampled with i_cells
//   o_busy         transmitter is sending a frame
//   o_done         one-cycle pulse after the last beat is sent
//   o_sync_active  frame marker to the peer
//   o_sync_out     serial lanes to the peer
//   i_sync_active  frame marker from the peer
//   i_sync_in      serial lanes from the peer
//   o_cells        last committed received cells
//   o_corner       last committed received corner
//   o_valid        pulse when o_cells/o_corner update
//   o_parity_err   pulse when a complete frame fails parity
//   o_frame_err    pulse when the peer frame ends early
module silife_grid_sync_edge_lanes #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 1,
    parameter int PARITY = 1
) (
    input  logic             i_sync_clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_cells,
    input  logic             i_corner,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sync_active,
    output logic [LANES-1:0] o_sync_out,
    input  logic             i_sync_active,
    input  logic [LANES-1:0] i_sync_in,
    output logic [WIDTH-1:0] o_cells,
    output logic             o_corner,
    output logic             o_valid,
    output logic             o_parity_err,
    output logic             o_frame_err
);

    localparam int N      = WIDTH + 1;
    localparam int DBEATS = (N + LANES - 1) / LANES;
    localparam int BEATS  = DBEATS + ((PARITY != 0) ? 1 : 0);
    localparam int CW     = $clog2(BEATS + 1);
    localparam int IW     = $clog2(N);

    localparam logic [CW-1:0] DBEATS_C = CW'(DBEATS);
    localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C   = CW'(BEATS - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_WAIT_LOW} rx_state_t;

    // ---------------------------------------------------------------- TX
    tx_state_t        tx_state, tx_state_n;
    logic [CW-1:0]    tx_cnt, tx_cnt_n;
    logic [N-1:0]     tx_sh, tx_sh_n;
    logic [LANES-1:0] tx_par, tx_par_n;
    logic [LANES-1:0] sync_out_n;
    logic             sync_active_n;
    logic             done_n;

    always_ff @(posedge i_sync_clk) begin
        if (reset) begin
            tx_state      <= TX_IDLE;
            tx_cnt        <= '0;
            tx_sh         <= '0;
            tx_par        <= '0;
            o_sync_out    <= '0;
            o_sync_active <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            tx_state      <= tx_state_n;
            tx_cnt        <= tx_cnt_n;
            tx_sh         <= tx_sh_n;
            tx_par        <= tx_par_n;
            o_sync_out    <= sync_out_n;
            o_sync_active <= sync_active_n;
            o_done        <= done_n;
        end
    end

    // Beats leave through a registered output, so beat b is launched while
    // tx_cnt==b and the extra cnt==BEATS cycle produces the trailing o_done.
    // Shifting the N-bit snapshot right fills zeros, which pads the last
    // data beat when N is not a multiple of LANES.
    always_comb begin
        tx_state_n    = tx_state;
        tx_cnt_n      = tx_cnt;
        tx_sh_n       = tx_sh;
        tx_par_n      = tx_par;
        sync_out_n    = '0;
        sync_active_n = 1'b0;
        done_n        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (i_start) begin
                    tx_sh_n    = {i_corner, i_cells};
                    tx_cnt_n   = '0;
                    tx_par_n   = '0;
                    tx_state_n = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_cnt < DBEATS_C) begin
                    sync_out_n    = tx_sh[LANES-1:0];
                    sync_active_n = 1'b1;
                    tx_sh_n       = tx_sh >> LANES;
                    tx_par_n      = tx_par ^ tx_sh[LANES-1:0];
                    tx_cnt_n      = tx_cnt + CW'(1);
                end else if (tx_cnt < BEATS_C) begin
                    sync_out_n    = tx_par;
                    sync_active_n = 1'b1;
                    tx_cnt_n      = tx_cnt + CW'(1);
                end else begin
                    done_n     = 1'b1;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign o_busy = (tx_state == TX_SEND);

    // ---------------------------------------------------------------- RX
    // The pad inputs are registered once; the FSM works on the registered
    // copy, so a beat sampled at edge j is acted on at edge j+1.
    logic             rx_act_q;
    logic [LANES-1:0] rx_in_q;
    rx_state_t        rx_state, rx_state_n;
    logic [CW-1:0]    rx_cnt, rx_cnt_n;
    logic [N-1:0]     rx_sh, rx_sh_n;
    logic [LANES-1:0] rx_par, rx_par_n;
    logic [WIDTH-1:0] cells_n;
    logic             corner_n, valid_n, perr_n, ferr_n;
    logic [CW-1:0]    rx_idx;
    logic [N-1:0]     rx_sh_acc;
    logic [LANES-1:0] rx_par_acc;
    int unsigned      rx_base;

    always_ff @(posedge i_sync_clk) begin
        if (reset) begin
            rx_act_q     <= 1'b0;
            rx_in_q      <= '0;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_sh        <= '0;
            rx_par       <= '0;
            o_cells      <= '0;
            o_corner     <= 1'b0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            rx_act_q     <= i_sync_active;
            rx_in_q      <= i_sync_in;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_sh        <= rx_sh_n;
            rx_par       <= rx_par_n;
            o_cells      <= cells_n;
            o_corner     <= corner_n;
            o_valid      <= valid_n;
            o_parity_err <= perr_n;
            o_frame_err  <= ferr_n;
        end
    end

    always_comb begin
        // Beat index and running parity as if the current input is a beat;
        // from IDLE the incoming beat is beat 0 with fresh parity.
        rx_idx     = (rx_state == RX_IDLE) ? '0 : rx_cnt;
        rx_par_acc = ((rx_state == RX_IDLE) ? '0 : rx_par) ^ rx_in_q;
        rx_base    = 32'(rx_idx) * LANES;
        rx_sh_acc  = rx_sh;
        if (rx_idx < DBEATS_C) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (rx_base + l < N) begin
                    rx_sh_acc[IW'(rx_base + l)] = rx_in_q[l];
                end
            end
        end

        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_sh_n    = rx_sh;
        rx_par_n   = rx_par;
        cells_n    = o_cells;
        corner_n   = o_corner;
        valid_n    = 1'b0;
        perr_n     = 1'b0;
        ferr_n     = 1'b0;
        case (rx_state)
            RX_IDLE, RX_RECV: begin
                if (rx_act_q) begin
                    rx_sh_n  = rx_sh_acc;
                    rx_par_n = rx_par_acc;
                    if (rx_idx == LAST_C) begin
                        rx_cnt_n   = '0;
                        rx_state_n = RX_WAIT_LOW;
                        if ((PARITY == 0) || (rx_par_acc == '0)) begin
                            cells_n  = rx_sh_acc[WIDTH-1:0];
                            corner_n = rx_sh_acc[WIDTH];
                            valid_n  = 1'b1;
                        end else begin
                            perr_n = 1'b1;
                        end
                    end else begin
                        rx_cnt_n   = rx_idx + CW'(1);
                        rx_state_n = RX_RECV;
                    end
                end else if (rx_state == RX_RECV) begin
                    ferr_n     = 1'b1;
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                end
            end
            RX_WAIT_LOW: begin
                if (!rx_act_q) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_silife_grid_sync_edge_lanes.sv
module tb_silife_grid_sync_edge_lanes;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int P  = 1;
    localparam int N  = W + 1;
    localparam int DB = 9;        // ceil(33/4)
    localparam int B  = DB + P;   // 10 beats on the 4-lane link
    localparam int B1 = 34;       // 33 data beats + parity on the 1-lane link

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 4-lane DUT; its receiver sees either its own transmitter or the bench
    logic         start, corner;
    logic [W-1:0] cells;
    logic         busy, done, sact;
    logic [L-1:0] sout;
    logic         ract;
    logic [L-1:0] rin;
    logic [W-1:0] rcells;
    logic         rcorner, valid, perr, ferr;
    logic         lb, drv_act;
    logic [L-1:0] drv_in;

    assign ract = lb ? sact : drv_act;
    assign rin  = lb ? sout : drv_in;

    // 1-lane DUT in permanent loopback
    logic         start1, corner1;
    logic [W-1:0] cells1;
    logic         busy1, done1, sact1;
    logic [0:0]   sout1;
    logic [W-1:0] rcells1;
    logic         rcorner1, valid1, perr1, ferr1;

    silife_grid_sync_edge_lanes #(.WIDTH(W), .LANES(L), .PARITY(P)) u_dut (
        .i_sync_clk(clk), .reset(reset), .i_start(start), .i_cells(cells),
        .i_corner(corner), .o_busy(busy), .o_done(done), .o_sync_active(sact),
        .o_sync_out(sout), .i_sync_active(ract), .i_sync_in(rin),
        .o_cells(rcells), .o_corner(rcorner), .o_valid(valid),
        .o_parity_err(perr), .o_frame_err(ferr)
    );

    silife_grid_sync_edge_lanes #(.WIDTH(W), .LANES(1), .PARITY(1)) u_dut1 (
        .i_sync_clk(clk), .reset(reset), .i_start(start1), .i_cells(cells1),
        .i_corner(corner1), .o_busy(busy1), .o_done(done1), .o_sync_active(sact1),
        .o_sync_out(sout1), .i_sync_active(sact1), .i_sync_in(sout1),
        .o_cells(rcells1), .o_corner(rcorner1), .o_valid(valid1),
        .o_parity_err(perr1), .o_frame_err(ferr1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an output event, expected none (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic [2:0]   kind;
        logic [W-1:0] cells;
        logic         corner;
        int           cyc;
    } rx_exp_t;

    rx_exp_t      rxq[$];
    rx_exp_t      rx1q[$];
    logic [L-1:0] txq[$];
    int           fbq[$];
    int           doneq[$];

    // Beat b, lane l carries payload bit b*L+l (0 past the end); the last
    // beat is the XOR of every data beat on that lane.
    function automatic logic [L-1:0] beat_of(input logic [N-1:0] pl, input int b);
        logic [L-1:0] r;
        r = '0;
        if (b < DB) begin
            for (int l = 0; l < L; l++)
                if (b * L + l < N) r[l] = pl[b*L+l];
        end else begin
            for (int d = 0; d < DB; d++)
                for (int l = 0; l < L; l++)
                    if (d * L + l < N) r[l] ^= pl[d*L+l];
        end
        return r;
    endfunction

    // s = cycle count at the negedge where i_start is raised.
    // Beat 0 is visible 2 counts later, o_done BEATS+2, o_valid BEATS+3
    // (BEATS+2 edges after the edge that accepts i_start).
    task automatic push_tx_frame(input logic [N-1:0] pl, input int s);
        for (int b = 0; b < B; b++) txq.push_back(beat_of(pl, b));
        fbq.push_back(s + 2);
        doneq.push_back(s + B + 2);
    endtask

    task automatic drive_frame(input logic [N-1:0] pl, input int nb, input int fb,
                               input logic [L-1:0] mask, output int last_c);
        last_c = cyc;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            drv_act = 1'b1;
            drv_in  = beat_of(pl, b) ^ ((b == fb) ? mask : '0);
            last_c  = cyc;
        end
        @(negedge clk);
        drv_act = 1'b0;
        drv_in  = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_done"},   done,   0);
        chk({tag, "_sact"},   sact,   0);
        chk({tag, "_sout"},   sout,   0);
        chk({tag, "_cells"},  rcells, 0);
        chk({tag, "_corner"}, rcorner, 0);
        chk({tag, "_valid"},  valid,  0);
        chk({tag, "_perr"},   perr,   0);
        chk({tag, "_ferr"},   ferr,   0);
        chk({tag, "_busy1"},  busy1,  0);
    endtask

    // Monitor for the 4-lane DUT
    initial begin
        logic    prev_act;
        rx_exp_t e;
        prev_act = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sact) begin
                if (!prev_act) begin
                    if (fbq.size() == 0) unexpected("tx_frame_start");
                    else chk("tx_first_beat_cycle", cyc, fbq.pop_front());
                end
                if (txq.size() == 0) unexpected("tx_beat");
                else chk("tx_beat", sout, txq.pop_front());
            end
            prev_act = sact;
            if (done) begin
                if (doneq.size() == 0) unexpected("tx_done");
                else chk("tx_done_cycle", cyc, doneq.pop_front());
            end
            if (valid || perr || ferr) begin
                if (rxq.size() == 0) unexpected("rx_event");
                else begin
                    e = rxq.pop_front();
                    chk("rx_kind", {valid, perr, ferr}, e.kind);
                    chk("rx_cells", rcells, e.cells);
                    chk("rx_corner", rcorner, e.corner);
                    chk("rx_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Monitor for the 1-lane DUT
    initial begin
        int      nbeats;
        rx_exp_t e;
        nbeats = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sact1) nbeats++;
            if (done1) begin
                chk("lane1_beat_count", nbeats, B1);
                nbeats = 0;
            end
            if (valid1 || perr1 || ferr1) begin
                if (rx1q.size() == 0) unexpected("lane1_rx_event");
                else begin
                    e = rx1q.pop_front();
                    chk("lane1_rx_kind", {valid1, perr1, ferr1}, e.kind);
                    chk("lane1_rx_cells", rcells1, e.cells);
                    chk("lane1_rx_corner", rcorner1, e.corner);
                    chk("lane1_rx_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int   s, s2, last_c;
        logic found;
        reset = 1'b1; start = 1'b0; cells = '0; corner = 1'b0;
        start1 = 1'b0; cells1 = '0; corner1 = 1'b0;
        lb = 1'b1; drv_act = 1'b0; drv_in = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Frame A on both links; 4-lane beats are the nibbles of the payload
        s = cyc;
        start = 1'b1; cells = 32'hA5A5_0F0F; corner = 1'b1;
        start1 = 1'b1; cells1 = 32'hA5A5_0F0F; corner1 = 1'b1;
        txq.push_back(4'hF); txq.push_back(4'h0); txq.push_back(4'hF); txq.push_back(4'h0);
        txq.push_back(4'h5); txq.push_back(4'hA); txq.push_back(4'h5); txq.push_back(4'hA);
        txq.push_back(4'h1); txq.push_back(4'h1);
        fbq.push_back(s + 2);
        doneq.push_back(s + B + 2);
        rxq.push_back('{K_VALID, 32'hA5A5_0F0F, 1'b1, s + B + 3});
        rx1q.push_back('{K_VALID, 32'hA5A5_0F0F, 1'b1, s + B1 + 3});
        @(negedge clk);
        start = 1'b0; start1 = 1'b0; cells = '0; corner = 1'b0; cells1 = '0; corner1 = 1'b0;
        repeat (B1 + 8) @(negedge clk);

        // Lane 2 flipped on beat 3: parity error, outputs keep frame A
        lb = 1'b0;
        repeat (2) @(negedge clk);
        drive_frame({1'b0, 32'h1234_5678}, B, 3, 4'b0100, last_c);
        rxq.push_back('{K_PERR, 32'hA5A5_0F0F, 1'b1, last_c + 2});
        repeat (4) @(negedge clk);

        // Marker drops after 5 of 10 beats: frame error, outputs unchanged
        drive_frame({1'b0, 32'h1234_5678}, 5, -1, '0, last_c);
        rxq.push_back('{K_FERR, 32'hA5A5_0F0F, 1'b1, last_c + 3});
        repeat (4) @(negedge clk);

        // Next complete clean frame commits
        drive_frame({1'b0, 32'h1234_5678}, B, -1, '0, last_c);
        rxq.push_back('{K_VALID, 32'h1234_5678, 1'b0, last_c + 2});
        repeat (4) @(negedge clk);
        lb = 1'b1;
        repeat (2) @(negedge clk);

        // Snapshot: inputs change and start re-asserts during SEND
        s = cyc;
        start = 1'b1; cells = 32'hDEAD_BEEF; corner = 1'b0;
        push_tx_frame({1'b0, 32'hDEAD_BEEF}, s);
        rxq.push_back('{K_VALID, 32'hDEAD_BEEF, 1'b0, s + B + 3});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        cells = 32'hFFFF_FFFF; corner = 1'b1; start = 1'b1;
        chk("busy_during_send", busy, 1);
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: start raised in the o_done cycle
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("done_seen", found, 1);
        s2 = cyc;
        start = 1'b1; cells = 32'h0000_0001; corner = 1'b1;
        push_tx_frame({1'b1, 32'h0000_0001}, s2);
        rxq.push_back('{K_VALID, 32'h0000_0001, 1'b1, s2 + B + 3});
        @(negedge clk);
        start = 1'b0;
        repeat (B + 6) @(negedge clk);

        // Reset while beat 4 is on the wire
        s = cyc;
        start = 1'b1; cells = 32'h0F0F_F0F0; corner = 1'b1;
        push_tx_frame({1'b1, 32'h0F0F_F0F0}, s);
        rxq.push_back('{K_VALID, 32'h0F0F_F0F0, 1'b1, s + B + 3});
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("beat4_active_before_reset", sact, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset_mid");
        txq.delete(); fbq.delete(); doneq.delete(); rxq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (B + 6) @(negedge clk);

        // Recovery frame after the abort
        s = cyc;
        start = 1'b1; cells = 32'h8000_0001; corner = 1'b0;
        push_tx_frame({1'b0, 32'h8000_0001}, s);
        rxq.push_back('{K_VALID, 32'h8000_0001, 1'b0, s + B + 3});
        @(negedge clk);
        start = 1'b0;
        repeat (B + 8) @(negedge clk);

        chk("rx_events_outstanding", rxq.size(), 0);
        chk("lane1_events_outstanding", rx1q.size(), 0);
        chk("tx_beats_outstanding", txq.size(), 0);
        chk("tx_done_outstanding", doneq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
